// File: rtl/expander12_pkg.sv
// expander_pkg: shared types and constants for the expander12 slice.
//   W             : packed word width (fixed at 12, one bit per output wire)
//   word_t        : packed word type
//   DEFAULT_DEPTH : default elastic-buffer depth
//   ptr_w()       : pointer width for a given depth
package expander_pkg;

   localparam int W             = 12;
   localparam int DEFAULT_DEPTH = 2;

   typedef logic [W-1:0] word_t;

   // Pointer width for a power-of-two depth; count uses one extra bit
   // so that FULL (== depth) is representable.
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/expander12_if.sv
// expander12_if: packed-word handshake bundle between producer, expander
// and consumer.
//   in_valid/in_ready/in_word : producer side
//   out_valid/out_ready       : consumer side (data leaves on o0..o11)
//   in_par                    : even parity of in_word (EXPANDER12_PARITY_EN only)
//
// Handshake rule (both sides): a transfer happens on a rising clk edge
// exactly when valid && ready are both high. valid must not depend on
// ready; ready of this block depends only on registered state.
interface expander12_if;
   import expander_pkg::*;

   logic  in_valid;
   logic  in_ready;
   word_t in_word;
   logic  out_valid;
   logic  out_ready;
`ifdef EXPANDER12_PARITY_EN
   logic  in_par;

   modport master (output in_valid, in_word, in_par, out_ready,
                   input  in_ready, out_valid);
   modport slave  (input  in_valid, in_word, in_par, out_ready,
                   output in_ready, out_valid);
`else
   modport master (output in_valid, in_word, out_ready,
                   input  in_ready, out_valid);
   modport slave  (input  in_valid, in_word, out_ready,
                   output in_ready, out_valid);
`endif

endinterface

// File: rtl/expander12_fifo.sv
// expander_fifo: generic DEPTH-entry elastic buffer with valid/ready on
// both sides.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : write handshake, in_data stored on transfer
//   out_valid/out_ready   : read handshake, out_data is the head entry
//   count                 : occupancy 0..DEPTH (EMPTY / PARTIAL / FULL)
// Occupancy is the only state; in_ready/out_valid decode it directly so
// neither ready path is combinational through the other side.
module expander_fifo
   import expander_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int DW    = W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DW-1:0]            in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DW-1:0]            out_data,
   output logic [ptr_w(DEPTH):0]    count
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   assign in_ready  = (count != FULL_CNT);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Head is forced to zero when empty so stale storage never shows.
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: it is only observed when count != 0.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

endmodule

// File: rtl/expander12.sv
// expander12: packed 12-bit word in, 12 individual wires out, through a
// DEPTH-entry elastic buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : expander12_if.slave (in_valid/in_ready/in_word,
//                out_valid/out_ready, in_par when parity enabled)
//   o0..o11    : bits of the head word (ok = word[k]), 0 when empty
//   count      : occupancy 0..DEPTH
//   drop_err   : sticky, set when a word is offered while the buffer is full
//   par_err    : head word parity mismatch (EXPANDER12_PARITY_EN only)
// Optional feature macro: EXPANDER12_PARITY_EN.
module expander12
   import expander_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   expander12_if.slave       bus,
   output logic              o0,
   output logic              o1,
   output logic              o2,
   output logic              o3,
   output logic              o4,
   output logic              o5,
   output logic              o6,
   output logic              o7,
   output logic              o8,
   output logic              o9,
   output logic              o10,
   output logic              o11,
   output logic [2:0]        count,
`ifdef EXPANDER12_PARITY_EN
   output logic              par_err,
`endif
   output logic              drop_err
);

`ifdef EXPANDER12_PARITY_EN
   localparam int DW = W + 1;   // parity bit stored above the word
`else
   localparam int DW = W;
`endif

   logic [DW-1:0]           fifo_in;
   logic [DW-1:0]           fifo_out;
   logic [ptr_w(DEPTH):0]   fifo_count;
   word_t                   head;

`ifdef EXPANDER12_PARITY_EN
   assign fifo_in = {bus.in_par, bus.in_word};
   assign par_err = bus.out_valid && (^fifo_out[W-1:0] ^ fifo_out[W]);
`else
   assign fifo_in = bus.in_word;
`endif

   expander_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (fifo_in),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (fifo_out),
      .count     (fifo_count)
   );

   assign head  = fifo_out[W-1:0];
   assign count = 3'(fifo_count);

   assign o0  = head[0];
   assign o1  = head[1];
   assign o2  = head[2];
   assign o3  = head[3];
   assign o4  = head[4];
   assign o5  = head[5];
   assign o6  = head[6];
   assign o7  = head[7];
   assign o8  = head[8];
   assign o9  = head[9];
   assign o10 = head[10];
   assign o11 = head[11];

   // Refused offers are a producer protocol violation; latch until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              drop_err <= 1'b0;
      else if (bus.in_valid && !bus.in_ready)  drop_err <= 1'b1;
   end

endmodule

// File: tb/tb_expander12.sv
// tb_expander12: randomized and directed stimulus for expander12, checked
// against a queue-based model of a DEPTH-entry FIFO.
module tb_expander12;
   import expander_pkg::*;

   localparam int DEPTH = DEFAULT_DEPTH;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   expander12_if bus ();

   logic o0, o1, o2, o3, o4, o5, o6, o7, o8, o9, o10, o11;
   logic [2:0] count;
   logic drop_err;
`ifdef EXPANDER12_PARITY_EN
   logic par_err;
`endif
   logic [11:0] obs_word;
   assign obs_word = {o11, o10, o9, o8, o7, o6, o5, o4, o3, o2, o1, o0};

   expander12 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .o0 (o0), .o1 (o1), .o2 (o2), .o3 (o3), .o4 (o4), .o5 (o5),
      .o6 (o6), .o7 (o7), .o8 (o8), .o9 (o9), .o10 (o10), .o11 (o11),
      .count    (count),
`ifdef EXPANDER12_PARITY_EN
      .par_err  (par_err),
`endif
      .drop_err (drop_err)
   );

   // ---------------- scoreboard ----------------
   logic [W:0] exp_q[$];    // {parity, word}, head at index 0
   logic       drop_m;
   logic       cur_par;
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [W:0] head;
      head = (exp_q.size() != 0) ? exp_q[0] : '0;
      check({tag, ".word"},      32'(obs_word),      32'(head[W-1:0]));
      check({tag, ".count"},     32'(count),         32'(exp_q.size()));
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_q.size() != 0));
      check({tag, ".in_ready"},  32'(bus.in_ready),  32'(exp_q.size() != DEPTH));
      check({tag, ".drop_err"},  32'(drop_err),      32'(drop_m));
`ifdef EXPANDER12_PARITY_EN
      check({tag, ".par_err"},   32'(par_err),
            32'((exp_q.size() != 0) && ((^head[W-1:0]) != head[W])));
`endif
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic v, input word_t w, input logic rdy, input logic par);
      bus.in_valid  = v;
      bus.in_word   = w;
      bus.out_ready = rdy;
      cur_par       = par;
`ifdef EXPANDER12_PARITY_EN
      bus.in_par    = par;
`endif
   endtask

   // One clock: model the edge from the inputs held now, then compare.
   task automatic step(input string tag);
      int   sz;
      logic do_push, do_pop;
      logic [W:0] entry;
      sz      = exp_q.size();
      do_push = bus.in_valid && (sz < DEPTH);
      do_pop  = bus.out_ready && (sz > 0);
      entry   = {cur_par, bus.in_word};
      if (bus.in_valid && sz == DEPTH) drop_m = 1'b1;
      @(posedge clk);
      #1;
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(entry);
      check_outputs(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      word_t w;
      word_t a5c;
      drop_m = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // single word with immediate consumer
      a5c = 12'hA5C;
      drive(1'b1, a5c, 1'b1, ^a5c);
      step("a5c_push");
      for (int k = 0; k < 12; k++) check($sformatf("a5c.o%0d", k), 32'(obs_word[k]), 32'(a5c[k]));
      drive(1'b0, '0, 1'b1, 1'b0);
      step("a5c_drain");

      // fill with consumer stalled, head held stable
      drive(1'b1, 12'h001, 1'b0, 1'b1);
      step("fill_001");
      drive(1'b1, 12'hFFF, 1'b0, 1'b0);
      step("fill_fff");
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("hold");

      // continuous streaming, one word per cycle, pointers wrap many times
      drive(1'b0, '0, 1'b1, 1'b0);
      step("drain_pre");
      step("drain_pre2");
      for (int i = 0; i < 256; i++) begin
         w = 12'(i);
         drive(1'b1, w, 1'b1, ^w);
         step("stream");
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      step("stream_end");

      // random traffic from a producer that respects in_ready
      for (int i = 0; i < 400; i++) begin
         w = 12'($urandom_range(0, 4095));
         drive(($urandom_range(0, 2) != 0) && (exp_q.size() < DEPTH), w,
               1'($urandom_range(0, 1)), (^w) ^ ($urandom_range(0, 7) == 0));
         step("rand");
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      repeat (DEPTH) step("rand_drain");

      // offer to a full buffer: refused, sticky drop_err, order preserved
      drive(1'b1, 12'h001, 1'b0, 1'b1);
      step("ovf_fill1");
      drive(1'b1, 12'hFFF, 1'b0, 1'b0);
      step("ovf_fill2");
      drive(1'b1, 12'h123, 1'b1, 1'b0);
      step("ovf_push");
      drive(1'b0, '0, 1'b1, 1'b0);
      step("ovf_drain1");
      step("ovf_drain2");
      step("ovf_sticky");

`ifdef EXPANDER12_PARITY_EN
      drive(1'b1, 12'h003, 1'b0, 1'b1);
      step("par_bad");
      check("par_bad.flag", 32'(par_err), 32'(1));
      drive(1'b0, '0, 1'b1, 1'b0);
      step("par_pop");
      drive(1'b1, 12'h003, 1'b0, 1'b0);
      step("par_good");
      check("par_good.flag", 32'(par_err), 32'(0));
      drive(1'b0, '0, 1'b1, 1'b0);
      step("par_pop2");
`endif

      // asynchronous reset mid-cycle with two words buffered
      drive(1'b1, 12'h5A5, 1'b0, 1'b0);
      step("ar_fill1");
      drive(1'b1, 12'h3C3, 1'b0, 1'b0);
      step("ar_fill2");
      drive(1'b0, '0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      drop_m = 1'b0;
      check_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step("after_rst");
      drive(1'b1, 12'h7E1, 1'b1, ^(12'h7E1));
      step("after_rst_push");
      drive(1'b0, '0, 1'b1, 1'b0);
      step("after_rst_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
